// File: rtl/vb_sched_pkg.sv
// vb_sched_pkg: shared words, default lengths and FSM states for the VB attach scheduler
package vb_sched_pkg;
  localparam logic [15:0] HDR_WORD = 16'hAAAA;
  localparam logic [15:0] TRAILER_WORD = 16'h5554;
  localparam int CB_LEN = 50;
  localparam int VB_LEN = 16;
  localparam int FRAME_LEN = 68;
  typedef enum logic [2:0] {IDLE, ARB, WAIT_HDR, FWD, HOLD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant of first requester from ptr upward (or from 0 when FIXED)
module rr_arbiter #(
  parameter int N = 4,
  parameter bit FIXED = 1'b0,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    // scan from farthest to nearest so the nearest requester is written last
    for (int i = N - 1; i >= 0; i--) begin
      j = (FIXED ? '0 : ptr) + W'(i);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/vb_attach_sched.sv
// vb_attach_sched: one VB lane per CB frame onto the merger's VB bus; VB_SCHED_FIXED_PRIO_EN selects fixed priority
module vb_attach_sched
  import vb_sched_pkg::*;
#(
  parameter int NLANE = 4,
  parameter logic [15:0] HDR = HDR_WORD,
  parameter int VB_LEN = vb_sched_pkg::VB_LEN,
  parameter int HDR_TIMEOUT = 32,
  parameter int FRAME_LEN = vb_sched_pkg::FRAME_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          cb_in,
  input  logic [NLANE-1:0]     vb_req,
  input  logic [16*NLANE-1:0]  vb_in,
  output logic [15:0]          vb_out,
  output logic [NLANE-1:0]     grant,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 drop_pulse,
  output logic [15:0]          drop_cnt
);
  localparam int W = $clog2(NLANE);
  state_t state;
  logic [6:0] frame_t, hdr_t;
  logic [7:0] wcnt;
  logic [W-1:0] gidx, rr_ptr, arb_idx;
  logic [NLANE-1:0] arb_gnt;
  logic [15:0] lane;
  logic abort, tmo, fin;
`ifdef VB_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
  assign rr_ptr = '0;
`else
  localparam bit FIXED = 1'b0;
  always_ff @(posedge clk)
    if (rst) rr_ptr <= '0;
    else if (abort || tmo || fin) rr_ptr <= gidx + W'(1);
`endif
  rr_arbiter #(.N(NLANE), .FIXED(FIXED)) u_arb (
    .req(vb_req), .ptr(rr_ptr), .gnt(arb_gnt), .idx(arb_idx)
  );
  assign lane = vb_in[16*gidx +: 16];
  assign busy = state != IDLE;
  // frame window overrides everything; timeout is checked before the header
  assign abort = (state == WAIT_HDR || state == FWD) && frame_t == 7'(FRAME_LEN - 1);
  assign tmo = state == WAIT_HDR && !abort && hdr_t == 7'(HDR_TIMEOUT - 1);
  assign fin = state == FWD && !abort && wcnt == 8'(VB_LEN);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vb_out <= '0;
      grant <= '0;
      done_pulse <= 1'b0;
      drop_pulse <= 1'b0;
      drop_cnt <= '0;
      frame_t <= '0;
      hdr_t <= '0;
      wcnt <= '0;
      gidx <= '0;
    end else begin
      done_pulse <= fin;
      drop_pulse <= abort || tmo;
      frame_t <= (state == IDLE) ? '0 : frame_t + 7'd1;
      hdr_t <= (state == WAIT_HDR) ? hdr_t + 7'd1 : '0;
      if ((abort || tmo) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      vb_out <= (state == FWD && !abort) ? lane :
                (state == WAIT_HDR && !abort && !tmo && lane == HDR) ? HDR : '0;
      case (state)
        IDLE: if (cb_in == HDR) state <= |vb_req ? ARB : HOLD;
        ARB:
          if (|vb_req) begin
            grant <= arb_gnt;
            gidx <= arb_idx;
            state <= WAIT_HDR;
          end else state <= HOLD;
        WAIT_HDR:
          if (abort || tmo) begin
            grant <= '0;
            state <= abort ? IDLE : HOLD;
          end else if (lane == HDR) begin
            wcnt <= 8'd1;
            state <= FWD;
          end
        FWD:
          if (abort || fin) begin
            grant <= '0;
            state <= abort ? IDLE : HOLD;
          end else wcnt <= wcnt + 8'd1;
        HOLD: if (frame_t == 7'(FRAME_LEN - 1)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
